// File: rtl/truth_table_sweeper.sv
// Exhaustive truth-table sweeper: walks vec through 0..2^N_IN-1, samples dut_o after
// DWELL clocks per vector, records the observed table and scores it against EXP_TABLE.
module truth_table_sweeper #(
   parameter int                  N_IN      = 4,
   parameter int                  DWELL     = 1,
   parameter logic [2**N_IN-1:0]  EXP_TABLE = 16'h8000
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   output logic [N_IN-1:0]      vec,
   input  logic                 dut_o,
   output logic                 busy,
   output logic                 done,
   output logic                 pass,
   output logic [N_IN:0]        err_count,
   output logic [N_IN-1:0]      first_fail_idx,
   output logic                 first_fail_valid,
   output logic [2**N_IN-1:0]   obs_table
);

   localparam int DW_W = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam logic [DW_W-1:0] DW_LAST  = DW_W'(DWELL - 1);
   localparam logic [N_IN-1:0] VEC_LAST = '1;

   typedef enum logic [1:0] {IDLE, DRIVE, FINISH} state_t;

   state_t          state;
   logic [DW_W-1:0] dwell;
   logic            mism;
   logic [N_IN:0]   err_next;

   // err_next folds in the sample taken this edge so pass sees all vectors
   always_comb begin
      mism     = dut_o ^ EXP_TABLE[vec];
      err_next = err_count + {{N_IN{1'b0}}, mism};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state            <= IDLE;
         dwell            <= '0;
         vec              <= '0;
         busy             <= 1'b0;
         done             <= 1'b0;
         pass             <= 1'b0;
         err_count        <= '0;
         first_fail_idx   <= '0;
         first_fail_valid <= 1'b0;
         obs_table        <= '0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  state            <= DRIVE;
                  vec              <= '0;
                  dwell            <= '0;
                  err_count        <= '0;
                  first_fail_idx   <= '0;
                  first_fail_valid <= 1'b0;
                  obs_table        <= '0;
                  pass             <= 1'b0;
                  busy             <= 1'b1;
               end
            end
            DRIVE: begin
               if (dwell == DW_LAST) begin
                  obs_table[vec] <= dut_o;
                  err_count      <= err_next;
                  if (mism && !first_fail_valid) begin
                     first_fail_idx   <= vec;
                     first_fail_valid <= 1'b1;
                  end
                  if (vec == VEC_LAST) begin
                     state <= FINISH;
                     done  <= 1'b1;
                     busy  <= 1'b0;
                     pass  <= (err_next == '0);
                  end else begin
                     vec   <= vec + 1'b1;
                     dwell <= '0;
                  end
               end else begin
                  dwell <= dwell + 1'b1;
               end
            end
            FINISH: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
